// File: rtl/image_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : image_window_gen
//  Description : Raster-order pixel stream to 3x3 sliding window generator.
//                Four rotating line buffers; three are read while the fourth
//                fills. Border columns are replicated at the line edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module image_window_gen #(
   parameter int IMG_WIDTH = 512
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [7:0]  pixelData,
   input  logic        pixelValid,
   output logic [71:0] windowData,
   output logic        windowValid,
   input  logic        windowReady,
   output logic        lineDoneIntr,
   output logic        overflow
);

   localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int FW = $clog2(4 * IMG_WIDTH + 1);

   localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] COL_ONE    = CW'(1);
   localparam logic [FW-1:0] FILL_FULL  = FW'(4 * IMG_WIDTH);
   localparam logic [FW-1:0] FILL_START = FW'(3 * IMG_WIDTH);
   localparam logic [FW-1:0] FILL_LINE  = FW'(IMG_WIDTH);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_READ = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;

   // Line storage: [buffer][column]; contents are intentionally not reset.
   logic [7:0] line_mem [4][IMG_WIDTH];

   logic [CW-1:0] wr_col;
   logic [1:0]    wr_buf;
   logic [CW-1:0] rd_col;
   logic [1:0]    rd_buf;
   logic [FW-1:0] fill_count;

   logic          wr_accept;
   logic          rd_step;
   logic          rd_last;
   logic [CW-1:0] col_sel [3];
   logic [71:0]   window_next;

   // A pixel is only accepted while there is free space in the buffers.
   assign wr_accept = pixelValid && (fill_count != FILL_FULL);
   assign rd_last   = rd_step && (rd_col == COL_LAST);

   // Column taps with edge replication at both ends of the line.
   assign col_sel[0] = (rd_col == '0)       ? rd_col : rd_col - COL_ONE;
   assign col_sel[1] = rd_col;
   assign col_sel[2] = (rd_col == COL_LAST) ? rd_col : rd_col + COL_ONE;

   // Gather the nine window bytes from the three rows starting at rd_buf.
   for (genvar r = 0; r < 3; r++) begin : g_row
      logic [1:0] row_buf;
      assign row_buf = rd_buf + 2'(r);
      for (genvar c = 0; c < 3; c++) begin : g_col
         assign window_next[(r*3+c)*8 +: 8] = line_mem[row_buf][col_sel[c]];
      end
   end

   // Line buffer write port.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         line_mem[wr_buf][wr_col] <= pixelData;
      end
   end

   // Write pointer: column wraps at end of line and advances to the next buffer.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_col <= '0;
         wr_buf <= '0;
      end else if (wr_accept) begin
         if (wr_col == COL_LAST) begin
            wr_col <= '0;
            wr_buf <= wr_buf + 2'd1;
         end else begin
            wr_col <= wr_col + COL_ONE;
         end
      end
   end

   // Occupancy: grows per stored pixel, shrinks by a line when a read line completes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fill_count <= '0;
      end else begin
         fill_count <= fill_count + {{(FW-1){1'b0}}, wr_accept} - (rd_last ? FILL_LINE : '0);
      end
   end

   // Sticky flag set when a pixel arrives with all four buffers full.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         overflow <= 1'b0;
      end else if (pixelValid && (fill_count == FILL_FULL)) begin
         overflow <= 1'b1;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Read FSM next state; a read step happens when the output register is free.
   always_comb begin
      state_nxt = state;
      rd_step   = 1'b0;
      case (state)
         S_IDLE: begin
            if (fill_count >= FILL_START) begin
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            rd_step = !windowValid || windowReady;
            if (rd_step && (rd_col == COL_LAST)) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Read pointer: advances per read step, rotates buffer at end of line.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_col <= '0;
         rd_buf <= '0;
      end else if (rd_step) begin
         if (rd_col == COL_LAST) begin
            rd_col <= '0;
            rd_buf <= rd_buf + 2'd1;
         end else begin
            rd_col <= rd_col + COL_ONE;
         end
      end
   end

   // Output register: load on read step, hold while stalled, drop valid once taken.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         windowData   <= '0;
         windowValid  <= 1'b0;
         lineDoneIntr <= 1'b0;
      end else begin
         lineDoneIntr <= rd_last;
         if (rd_step) begin
            windowData  <= window_next;
            windowValid <= 1'b1;
         end else if (windowReady) begin
            windowValid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_image_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_window_gen
//  Description : Self-checking bench for image_window_gen (IMG_WIDTH = 4).
//                Expected windows are built from the bench's own pixel history
//                and queued as pixels are driven; a monitor pops and compares
//                them on every accepted window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_window_gen;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  pixelData;
   logic        pixelValid;
   logic [71:0] windowData;
   logic        windowValid;
   logic        windowReady;
   logic        lineDoneIntr;
   logic        overflow;

   always #5 clk = ~clk;

   image_window_gen #(.IMG_WIDTH(W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .pixelData    (pixelData),
      .pixelValid   (pixelValid),
      .windowData   (windowData),
      .windowValid  (windowValid),
      .windowReady  (windowReady),
      .lineDoneIntr (lineDoneIntr),
      .overflow     (overflow)
   );

   typedef struct {
      logic [71:0] data;
      logic        last;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   byte unsigned hist[$];
   int          lines_pushed = 0;
   int          n_vec = 0;
   int          n_err = 0;
   int          n_acc = 0;
   int          n_ld  = 0;
   int          base_acc;
   int          base_ld;
   logic [71:0] cap;

   task automatic chk_val(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Window for line k, column c from the stored pixel history with edge clamping.
   function automatic logic [71:0] exp_window(input int k, input int c);
      logic [71:0] w;
      int          cc;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < 3; j++) begin
            cc = c - 1 + j;
            if (cc < 0)     cc = 0;
            if (cc > W - 1) cc = W - 1;
            w[(r*3+j)*8 +: 8] = hist[(k + r) * W + cc];
         end
      end
      return w;
   endfunction

   task automatic model_store(input byte unsigned p);
      exp_t e;
      hist.push_back(p);
      if (hist.size() >= (lines_pushed + 3) * W) begin
         for (int c = 0; c < W; c++) begin
            e.data = exp_window(lines_pushed, c);
            e.last = (c == W - 1);
            sb.push_back(e);
         end
         lines_pushed++;
      end
   endtask

   task automatic send_pix(input logic [7:0] p, input bit store);
      pixelData  = p;
      pixelValid = 1'b1;
      @(posedge clk);
      #1;
      pixelValid = 1'b0;
      if (store) model_store(p);
   endtask

   task automatic wait_wv(input int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (windowValid) break;
      end
      chk_val("wait_wv", windowValid, 1);
   endtask

   task automatic drain(input string tag, input int max);
      for (int i = 0; i < max; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      chk_val(tag, sb.size(), 0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      chk_val("rst_data", windowData, 0);
      chk_val("rst_flags", {windowValid, lineDoneIntr, overflow}, 0);
      sb.delete();
      hist.delete();
      lines_pushed = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Scoreboard monitor: every accepted window must match the queue head.
   always @(negedge clk) begin
      if (rstn && windowValid && windowReady) begin
         n_acc++;
         if (sb.size() == 0) begin
            chk_val("extra_window", {71'd0, windowValid}, 0);
         end else begin
            mon_e = sb.pop_front();
            chk_val("win_data", windowData, mon_e.data);
            chk_val("line_done", lineDoneIntr, mon_e.last);
         end
      end
      if (rstn && lineDoneIntr) n_ld++;
   end

   initial begin
      rstn        = 1'b0;
      pixelData   = '0;
      pixelValid  = 1'b0;
      windowReady = 1'b0;
      #3;
      chk_val("por_data", windowData, 0);
      chk_val("por_flags", {windowValid, lineDoneIntr, overflow}, 0);
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;

      // First line: pixels 1..12 with ready held high.
      windowReady = 1'b1;
      for (int p = 1; p <= 12; p++) send_pix(8'(p), 1'b1);
      @(negedge clk); chk_val("lat_e0", windowValid, 0);
      @(negedge clk); chk_val("lat_e1", windowValid, 0);
      @(negedge clk); chk_val("lat_e2", windowValid, 1);
      chk_val("w0_line0", windowData, 72'h0A_09_09_06_05_05_02_01_01);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); chk_val("line0_run", windowValid, 1);
      end
      chk_val("w3_line0", windowData, 72'h0C_0C_0B_08_08_07_04_04_03);
      @(negedge clk); chk_val("line0_end", windowValid, 0);
      chk_val("ld_cnt1", n_ld, 1);
      drain("drain_l0", 5);

      // Second line with a 5-cycle stall on window 0.
      windowReady = 1'b0;
      for (int p = 13; p <= 16; p++) send_pix(8'(p), 1'b1);
      wait_wv(10);
      cap = windowData;
      chk_val("stall_w0", cap, 72'h0E_0D_0D_0A_09_09_06_05_05);
      repeat (5) begin
         @(negedge clk);
         chk_val("stall_wv", windowValid, 1);
         chk_val("stall_data", windowData, cap);
         chk_val("stall_rdcol", dut.rd_col, 1);
      end
      @(posedge clk); #1;
      windowReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk_val("release_run", windowValid, 1);
      end
      @(negedge clk); chk_val("release_end", windowValid, 0);
      chk_val("ld_cnt2", n_ld, 2);
      drain("drain_l1", 5);

      // Overflow: ready low, 17 pixels; the 17th must be dropped.
      windowReady = 1'b0;
      do_reset();
      base_ld = n_ld;
      for (int p = 101; p <= 116; p++) send_pix(8'(p), 1'b1);
      chk_val("ovf_before", overflow, 0);
      send_pix(8'd117, 1'b0);
      chk_val("ovf_set", overflow, 1);
      chk_val("fill_full", dut.fill_count, 16);
      @(posedge clk); #1;
      windowReady = 1'b1;
      drain("drain_ovf", 60);
      repeat (10) @(negedge clk);
      chk_val("ovf_no_more", windowValid, 0);
      chk_val("ovf_sticky", overflow, 1);
      chk_val("ovf_ld", n_ld, base_ld + 2);

      // Reset in the middle of a line after window 1 is taken.
      do_reset();
      windowReady = 1'b1;
      base_acc = n_acc;
      base_ld  = n_ld;
      for (int p = 201; p <= 212; p++) send_pix(8'(p), 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (n_acc >= base_acc + 2) break;
      end
      chk_val("mid_acc", n_acc, base_acc + 2);
      rstn = 1'b0;
      #1;
      chk_val("mid_rst_wv", windowValid, 0);
      chk_val("mid_rst_data", windowData, 0);
      sb.delete();
      hist.delete();
      lines_pushed = 0;
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (6) @(negedge clk);
      chk_val("mid_no_ld", n_ld, base_ld);
      for (int p = 221; p <= 231; p++) send_pix(8'(p), 1'b1);
      repeat (6) @(negedge clk);
      chk_val("mid_wait11", windowValid, 0);
      send_pix(8'd232, 1'b1);
      wait_wv(10);
      drain("drain_mid", 20);
      repeat (3) @(negedge clk);
      chk_val("mid_ld", n_ld, base_ld + 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
